// File: rtl/spi_slave_fifo_if.sv
// Host-side streaming and status bundle of spi_slave_fifo.
// The slave modport is the SPI block; the master modport is the packet logic.
interface spi_slave_fifo_if #(
  parameter int DATA_W = 8,
  parameter int LVL_W  = 5
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [LVL_W-1:0]  rx_level;
  logic [LVL_W-1:0]  tx_level;
  logic              rx_overflow;
  logic              tx_underflow;
  logic              frame_abort;
  logic              clear_errors;

  modport master (
    output tx_data, tx_valid, rx_ready, clear_errors,
    input  tx_ready, rx_data, rx_valid, rx_level, tx_level,
           rx_overflow, tx_underflow, frame_abort
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready, clear_errors,
    output tx_ready, rx_data, rx_valid, rx_level, tx_level,
           rx_overflow, tx_underflow, frame_abort
  );
endinterface

// File: rtl/spi_slave_fifo.sv
// Parametrised SPI slave with rx/tx FIFOs and chip-select framing.
// The host interface LVL_W must equal $clog2(FIFO_DEPTH)+1.
module spi_slave_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0,
  parameter int LSB_FIRST  = 0,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic SCLK,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic MISO_oe,
  spi_slave_fifo_if.slave host
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic IDLE_SCLK = (CPOL != 0);

  typedef enum logic [1:0] {F_WAIT, F_IDLE, F_ACTIVE} frame_t;
  frame_t state, state_next;

  logic sclk_s1, sclk_s2, sclk_d, ss_s1, ss_s2, mosi_s1, mosi_s2;
  logic [1:0] warm;
  logic ss_fall, ss_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_s1 <= IDLE_SCLK; sclk_s2 <= IDLE_SCLK; sclk_d <= IDLE_SCLK;
      ss_s1   <= 1'b1;      ss_s2   <= 1'b1;
      mosi_s1 <= 1'b0;      mosi_s2 <= 1'b0;
      warm    <= '0;
    end else begin
      sclk_s1 <= SCLK;  sclk_s2 <= sclk_s1; sclk_d <= sclk_s2;
      ss_s1   <= SS_n;  ss_s2   <= ss_s1;
      mosi_s1 <= MOSI;  mosi_s2 <= mosi_s1;
      warm    <= {warm[0], 1'b1};
    end
  end

  // F_WAIT holds off framing until SS_n has really been seen high after reset,
  // so a select held low through reset never starts a word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= F_WAIT;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    ss_fall    = 1'b0;
    ss_rise    = 1'b0;
    case (state)
      F_WAIT:   if (warm[1] && ss_s2) state_next = F_IDLE;
      F_IDLE:   if (!ss_s2) begin state_next = F_ACTIVE; ss_fall = 1'b1; end
      F_ACTIVE: if (ss_s2)  begin state_next = F_IDLE;   ss_rise = 1'b1; end
      default:  state_next = F_WAIT;
    endcase
  end

  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_shift, rx_next, rx_word, tx_shift;
  logic push_pend, in_frame, sclk_edge, lead, trail, sample_stb, shift_stb;
  logic word_done, tx_load;

  assign in_frame   = (state == F_ACTIVE) && !ss_s2;
  assign sclk_edge  = in_frame && (sclk_s2 != sclk_d);
  assign lead       = sclk_edge && (sclk_s2 != IDLE_SCLK);
  assign trail      = sclk_edge && (sclk_s2 == IDLE_SCLK);
  assign sample_stb = (CPHA != 0) ? trail : lead;
  assign shift_stb  = (CPHA != 0) ? lead : trail;
  assign word_done  = sample_stb && (bit_cnt == LAST_BIT);
  // bit_cnt is 0 on a shift edge only at a word boundary, which covers both CPHA load points.
  assign tx_load    = (shift_stb && (bit_cnt == '0)) || ((CPHA == 0) && ss_fall);
  assign rx_next    = (LSB_FIRST != 0) ? {mosi_s2, rx_shift[DATA_W-1:1]}
                                       : {rx_shift[DATA_W-2:0], mosi_s2};

  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  tx_wr, tx_rd, rx_wr, rx_rd;
  logic [LVL_W-1:0]  tx_count, rx_count;
  logic tx_empty, tx_push, tx_pop, rx_full, rx_push, rx_pop, rx_drop;

  assign tx_empty = (tx_count == '0);
  assign tx_push  = host.tx_valid && host.tx_ready;
  assign tx_pop   = tx_load && !tx_empty;
  assign rx_full  = (rx_count == FULL_LVL);
  assign rx_pop   = host.rx_valid && host.rx_ready;
  assign rx_push  = push_pend && (!rx_full || rx_pop);
  assign rx_drop  = push_pend && rx_full && !rx_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt     <= '0;
      rx_shift    <= '0;
      rx_word     <= '0;
      push_pend   <= 1'b0;
      tx_shift    <= '0;
      host.frame_abort <= 1'b0;
    end else begin
      push_pend        <= word_done;
      host.frame_abort <= ss_rise && (bit_cnt != '0);
      if (ss_fall || ss_rise) bit_cnt <= '0;
      else if (sample_stb)    bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
      if (sample_stb) rx_shift <= rx_next;
      if (word_done)  rx_word  <= rx_next;
      if (tx_load)        tx_shift <= tx_empty ? '0 : tx_mem[tx_rd];
      else if (shift_stb) tx_shift <= (LSB_FIRST != 0) ? (tx_shift >> 1) : (tx_shift << 1);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= host.tx_data;
    if (rx_push) rx_mem[rx_wr] <= rx_word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wr <= '0; tx_rd <= '0; tx_count <= '0;
      rx_wr <= '0; rx_rd <= '0; rx_count <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
      else if (!tx_push && tx_pop) tx_count <= tx_count - 1'b1;
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      if (rx_push && !rx_pop)      rx_count <= rx_count + 1'b1;
      else if (!rx_push && rx_pop) rx_count <= rx_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      host.rx_overflow  <= 1'b0;
      host.tx_underflow <= 1'b0;
    end else if (host.clear_errors) begin
      host.rx_overflow  <= 1'b0;
      host.tx_underflow <= 1'b0;
    end else begin
      if (rx_drop)              host.rx_overflow  <= 1'b1;
      if (tx_load && tx_empty)  host.tx_underflow <= 1'b1;
    end
  end

  assign host.tx_ready = (tx_count != FULL_LVL);
  assign host.tx_level = tx_count;
  assign host.rx_valid = (rx_count != '0);
  assign host.rx_level = rx_count;
  assign host.rx_data  = host.rx_valid ? rx_mem[rx_rd] : '0;
  assign MISO_oe       = !ss_s2;
  assign MISO          = !ss_s2 && ((LSB_FIRST != 0) ? tx_shift[0] : tx_shift[DATA_W-1]);
endmodule

// File: tb/tb_spi_slave_fifo.sv
// Bench for spi_slave_fifo: one mode-0 MSB-first depth-4 instance (index 4)
// and four LSB-first depth-16 instances for SPI modes 0..3 (index = mode).
module tb_spi_slave_fifo;
  localparam int HALF = 80;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       sclk_raw = 1'b0;
  logic       mosi = 1'b0;
  logic [4:0] ss_n = '1;
  wire  [4:0] miso_v;
  wire  [4:0] oe_v;

  logic [3:0][7:0] m_tx_data  = '0;
  logic [3:0]      m_tx_valid = '0;
  logic [3:0]      m_rx_ready = '0;
  wire  [3:0][7:0] m_rx_data;
  wire  [3:0]      m_rx_valid;
  wire  [3:0][4:0] m_rx_level;

  spi_slave_fifo_if #(.DATA_W(8), .LVL_W(3)) ifa ();

  spi_slave_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .CPOL(0), .CPHA(0), .LSB_FIRST(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .SCLK(sclk_raw), .SS_n(ss_n[4]), .MOSI(mosi),
    .MISO(miso_v[4]), .MISO_oe(oe_v[4]), .host(ifa)
  );

  for (genvar g = 0; g < 4; g++) begin : gm
    spi_slave_fifo_if #(.DATA_W(8), .LVL_W(5)) bus ();
    assign bus.tx_data      = m_tx_data[g];
    assign bus.tx_valid     = m_tx_valid[g];
    assign bus.rx_ready     = m_rx_ready[g];
    assign bus.clear_errors = 1'b0;
    assign m_rx_data[g]     = bus.rx_data;
    assign m_rx_valid[g]    = bus.rx_valid;
    assign m_rx_level[g]    = bus.rx_level;
    spi_slave_fifo #(.DATA_W(8), .FIFO_DEPTH(16), .CPOL(g / 2), .CPHA(g % 2), .LSB_FIRST(1)) dut (
      .clk(clk), .reset_n(reset_n), .SCLK((g >= 2) ? ~sclk_raw : sclk_raw), .SS_n(ss_n[g]),
      .MOSI(mosi), .MISO(miso_v[g]), .MISO_oe(oe_v[g]), .host(bus)
    );
  end

  int n_tests = 0;
  int n_fail  = 0;
  int abort_cnt = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];
  event last_lead;

  always @(posedge clk) if (ifa.frame_abort) abort_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit cpha_of(input int s);
    return (s == 1) || (s == 3);
  endfunction

  function automatic bit lsb_of(input int s);
    return s != 4;
  endfunction

  function automatic logic rx_valid_of(input int s);
    return (s == 4) ? ifa.rx_valid : m_rx_valid[s];
  endfunction

  function automatic logic [7:0] rx_data_of(input int s);
    return (s == 4) ? ifa.rx_data : m_rx_data[s];
  endfunction

  function automatic logic [31:0] rx_level_of(input int s);
    return (s == 4) ? 32'(ifa.rx_level) : 32'(m_rx_level[s]);
  endfunction

  task automatic push_tx(input int s, input logic [7:0] w);
    if (s == 4) begin ifa.tx_data = w; ifa.tx_valid = 1'b1; end
    else begin m_tx_data[s] = w; m_tx_valid[s] = 1'b1; end
    @(posedge clk); #1;
    if (s == 4) ifa.tx_valid = 1'b0; else m_tx_valid[s] = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_rx_ready(input int s, input logic v);
    if (s == 4) ifa.rx_ready = v; else m_rx_ready[s] = v;
  endtask

  task automatic clear_a();
    ifa.clear_errors = 1'b1;
    @(posedge clk); #1 ifa.clear_errors = 1'b0;
    @(negedge clk);
  endtask

  task automatic ss_fall(input int s);
    ss_n[s] = 1'b0;
    #(HALF);
  endtask

  task automatic ss_rise(input int s);
    #(HALF);
    ss_n[s] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Master side: full-period bit loop in the instance's CPHA and bit order.
  task automatic xfer(input int s, input logic [7:0] w, input int nbits, output logic [7:0] got);
    got = '0;
    for (int k = 0; k < nbits; k++) begin
      int idx;
      idx = lsb_of(s) ? k : 7 - k;
      if (!cpha_of(s)) begin
        mosi = w[idx];
        #(HALF); sclk_raw = 1'b1; got[idx] = miso_v[s];
        if (k == nbits - 1) -> last_lead;
        #(HALF); sclk_raw = 1'b0;
      end else begin
        #(HALF); sclk_raw = 1'b1; mosi = w[idx];
        #(HALF); sclk_raw = 1'b0; got[idx] = miso_v[s];
      end
    end
  endtask

  task automatic word_chk(input int s, input logic [7:0] w, input string name);
    logic [7:0] got, exp;
    xfer(s, w, 8, got);
    exp = (exp_miso.size() != 0) ? exp_miso.pop_front() : 8'h00;
    check(name, 32'(got), 32'(exp));
  endtask

  task automatic drain(input int s, input string name);
    int guard;
    logic [7:0] exp;
    guard = 0;
    while (rx_valid_of(s) && guard < 20) begin
      exp = (exp_rx.size() != 0) ? exp_rx.pop_front() : 8'hxx;
      check({name, "_rx_data"}, 32'(rx_data_of(s)), 32'(exp));
      set_rx_ready(s, 1'b1);
      @(posedge clk); #1 set_rx_ready(s, 1'b0);
      @(negedge clk);
      guard++;
    end
    check({name, "_rx_words_left"}, 32'(exp_rx.size()), 32'd0);
    exp_rx.delete();
  endtask

  typedef struct {
    int         sel;
    logic [7:0] tx;
    logic [7:0] mosi_w;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
  } vec_t;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[5];
    logic [7:0] got;
    int ab0;

    tbl[0] = '{sel: 4, tx: 8'hA5, mosi_w: 8'h3C, exp_miso: 8'hA5, exp_rx: 8'h3C};
    tbl[1] = '{sel: 0, tx: 8'h80, mosi_w: 8'h01, exp_miso: 8'h80, exp_rx: 8'h01};
    tbl[2] = '{sel: 1, tx: 8'h80, mosi_w: 8'h01, exp_miso: 8'h80, exp_rx: 8'h01};
    tbl[3] = '{sel: 2, tx: 8'h80, mosi_w: 8'h01, exp_miso: 8'h80, exp_rx: 8'h01};
    tbl[4] = '{sel: 3, tx: 8'h80, mosi_w: 8'h01, exp_miso: 8'h80, exp_rx: 8'h01};

    ifa.tx_data = '0; ifa.tx_valid = 1'b0; ifa.rx_ready = 1'b0; ifa.clear_errors = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    check("reset_tx_ready", 32'(ifa.tx_ready), 32'd1);
    check("reset_rx_valid_data", {23'd0, ifa.rx_valid, ifa.rx_data}, 32'd0);
    check("reset_levels", {26'd0, ifa.rx_level, ifa.tx_level}, 32'd0);
    check("reset_flags", {29'd0, ifa.rx_overflow, ifa.tx_underflow, ifa.frame_abort}, 32'd0);
    check("reset_miso_oe", {30'd0, miso_v[4], oe_v[4]}, 32'd0);

    foreach (tbl[i]) begin
      push_tx(tbl[i].sel, tbl[i].tx);
      exp_miso.push_back(tbl[i].exp_miso);
      exp_rx.push_back(tbl[i].exp_rx);
      ss_fall(tbl[i].sel);
      check($sformatf("vec%0d_miso_oe", i), 32'(oe_v[tbl[i].sel]), 32'd1);
      word_chk(tbl[i].sel, tbl[i].mosi_w, $sformatf("vec%0d_miso_word", i));
      ss_rise(tbl[i].sel);
      check($sformatf("vec%0d_rx_level", i), rx_level_of(tbl[i].sel), 32'd1);
      if (tbl[i].sel == 4) check("vec_a_rx_overflow", 32'(ifa.rx_overflow), 32'd0);
      drain(tbl[i].sel, $sformatf("vec%0d", i));
    end
    exp_miso.delete();

    // Four-word burst under one select.
    clear_a();
    for (int i = 1; i <= 4; i++) begin
      push_tx(4, 8'(i * 8'h11));
      exp_miso.push_back(8'(i * 8'h11));
    end
    check("burst_tx_ready_full", 32'(ifa.tx_ready), 32'd0);
    check("burst_tx_level_full", 32'(ifa.tx_level), 32'd4);
    ss_fall(4);
    for (int i = 1; i <= 4; i++) begin
      exp_rx.push_back(8'(8'hC0 + i));
      word_chk(4, 8'(8'hC0 + i), $sformatf("burst_miso%0d", i));
    end
    ss_rise(4);
    check("burst_tx_level", 32'(ifa.tx_level), 32'd0);
    check("burst_rx_level", 32'(ifa.rx_level), 32'd4);
    // Mode 0 reloads on the trailing edge after the last word, finding tx empty.
    check("burst_tail_underflow", 32'(ifa.tx_underflow), 32'd1);
    drain(4, "burst");

    // Underflow with an empty tx FIFO.
    clear_a();
    check("uf_cleared_before", 32'(ifa.tx_underflow), 32'd0);
    ss_fall(4);
    exp_rx.push_back(8'h5A);
    word_chk(4, 8'h5A, "uf_miso_zero");
    ss_rise(4);
    check("uf_flag_set", 32'(ifa.tx_underflow), 32'd1);
    drain(4, "uf");
    clear_a();
    check("uf_flag_cleared", 32'(ifa.tx_underflow), 32'd0);

    // Overflow: five words into a depth-4 rx FIFO, no host pops.
    ss_fall(4);
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_rx.push_back(8'(8'h60 + i));
      xfer(4, 8'(8'h60 + i), 8, got);
    end
    ss_rise(4);
    check("ov_rx_level", 32'(ifa.rx_level), 32'd4);
    check("ov_flag", 32'(ifa.rx_overflow), 32'd1);
    drain(4, "ov");
    clear_a();
    check("ov_flag_cleared", 32'(ifa.rx_overflow), 32'd0);

    // Same again, with the host pop landing in the cycle of the fifth push.
    ss_fall(4);
    for (int i = 1; i <= 4; i++) begin
      exp_rx.push_back(8'(8'h70 + i));
      xfer(4, 8'(8'h70 + i), 8, got);
    end
    exp_rx.push_back(8'h75);
    fork
      xfer(4, 8'h75, 8, got);
      begin
        @(last_lead);
        #30;
        check("ovpop_head", 32'(ifa.rx_data), 32'(exp_rx.pop_front()));
        ifa.rx_ready = 1'b1;
        #10 ifa.rx_ready = 1'b0;
      end
    join
    ss_rise(4);
    check("ovpop_rx_level", 32'(ifa.rx_level), 32'd4);
    check("ovpop_no_overflow", 32'(ifa.rx_overflow), 32'd0);
    drain(4, "ovpop");

    // Select released after five bits.
    clear_a();
    ab0 = abort_cnt;
    ss_fall(4);
    xfer(4, 8'hFF, 5, got);
    ss_rise(4);
    check("abort_pulses", 32'(abort_cnt - ab0), 32'd1);
    check("abort_rx_level", 32'(ifa.rx_level), 32'd0);
    ss_fall(4);
    exp_rx.push_back(8'h96);
    xfer(4, 8'h96, 8, got);
    ss_rise(4);
    check("abort_no_extra_pulse", 32'(abort_cnt - ab0), 32'd1);
    check("after_abort_rx_level", 32'(ifa.rx_level), 32'd1);
    drain(4, "after_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
